// File: rtl/sync_fifo_mem_ctrl_if.sv
// Bus bundle for the single-clock FIFO.
// The master drives requests and write data. The slave (the FIFO) returns
// the registered read data, the status flags and the sticky error flags.
interface sync_fifo_mem_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3
);

  // Request side
  logic                  wen;
  logic                  ren;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  clr_err;

  // Response / status side
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [PTR_WIDTH:0]    count;
  logic                  overflow;
  logic                  underflow;

  // Requester view
  modport master (
    output wen,
    output ren,
    output data_in,
    output clr_err,
    input  data_out,
    input  rd_valid,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  count,
    input  overflow,
    input  underflow
  );

  // FIFO view
  modport slave (
    input  wen,
    input  ren,
    input  data_in,
    input  clr_err,
    output data_out,
    output rd_valid,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output count,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/sync_fifo_mem_ctrl.sv
// Single-clock FIFO with integrated storage, binary pointers, an occupancy
// counter, registered full/empty/almost flags, a read-valid strobe and
// sticky overflow/underflow flags.
//
// Handshake: wen/ren are requests qualified by the flags registered at the
// start of the cycle. A write is taken when wen=1 and full=0; a read is taken
// when ren=1 and empty=0. A read in the same cycle does not make room for a
// write. A taken read shows up on data_out one clock later together with a
// one-cycle rd_valid pulse; otherwise data_out holds and rd_valid is 0.
// Requests against full/empty are dropped and only raise the error flags.
module sync_fifo_mem_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  sync_fifo_mem_ctrl_if.slave  bus
);

  typedef logic [PTR_WIDTH:0]    ptr_t;
  typedef logic [PTR_WIDTH-1:0]  idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam ptr_t DEPTH_C = ptr_t'(DEPTH);
  localparam ptr_t AF_C    = ptr_t'(AF_LEVEL);
  localparam ptr_t AE_C    = ptr_t'(AE_LEVEL);
  localparam ptr_t ONE     = ptr_t'(1);
  localparam ptr_t ZERO    = ptr_t'(0);

  // almost_full at count==0 is only true for a zero threshold
  localparam logic AF_RST  = (AF_LEVEL == 0);

  // Storage (not reset; empty=1 after reset blocks any stale read)
  word_t mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  ptr_t  wptr_q, rptr_q;
  ptr_t  count_q, count_nxt;

  // Registered status
  logic  full_q, empty_q, af_q, ae_q;
  logic  ovf_q, udf_q;
  logic  ovf_nxt, udf_nxt;

  // Read side outputs
  word_t data_out_q;
  logic  rd_valid_q;

  // Accepted accesses
  logic  wr_acc, rd_acc;

  idx_t  widx, ridx;

  assign widx = wptr_q[PTR_WIDTH-1:0];
  assign ridx = rptr_q[PTR_WIDTH-1:0];

  // Qualify requests with the flags held at the start of the cycle and
  // work out the occupancy and error flags for the next cycle
  always_comb begin
    wr_acc    = bus.wen & ~full_q;
    rd_acc    = bus.ren & ~empty_q;
    count_nxt = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + ONE;
      2'b01:   count_nxt = count_q - ONE;
      default: count_nxt = count_q;
    endcase
    // A new error event beats a clear in the same cycle
    ovf_nxt = (bus.wen & full_q)  | (ovf_q & ~bus.clr_err);
    udf_nxt = (bus.ren & empty_q) | (udf_q & ~bus.clr_err);
  end

  // Write port into storage
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[widx] <= bus.data_in;
    end
  end

  // Pointers and occupancy counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= ZERO;
      rptr_q  <= ZERO;
      count_q <= ZERO;
    end else begin
      if (wr_acc) begin
        wptr_q <= wptr_q + ONE;
      end
      if (rd_acc) begin
        rptr_q <= rptr_q + ONE;
      end
      count_q <= count_nxt;
    end
  end

  // Status flags registered from the next count, so they line up with count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= AF_RST;
      ae_q    <= 1'b1;
    end else begin
      full_q  <= (count_nxt == DEPTH_C);
      empty_q <= (count_nxt == ZERO);
      af_q    <= (count_nxt >= AF_C);
      ae_q    <= (count_nxt <= AE_C);
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_nxt;
      udf_q <= udf_nxt;
    end
  end

  // Registered read data and its one-cycle valid strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        data_out_q <= mem[ridx];
      end
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

`ifndef SYNTHESIS
  // The count-derived flags must agree with the pointer relationship
  a_full_ptr : assert property (@(posedge clk) disable iff (!rstn)
    full_q == ((wptr_q ^ rptr_q) == DEPTH_C));
  a_empty_ptr : assert property (@(posedge clk) disable iff (!rstn)
    empty_q == (wptr_q == rptr_q));
  a_count_ptr : assert property (@(posedge clk) disable iff (!rstn)
    count_q == ptr_t'(wptr_q - rptr_q));
`endif

endmodule
